// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryption engine: FSM states, S-array depth,
// plaintext character bounds and per-phase cycle costs.
package rc4_pkg;

  localparam int S_DEPTH              = 256;
  localparam int INIT_CYCLES          = S_DEPTH;
  localparam int KSA_CYCLES           = 6 * S_DEPTH;
  localparam int PRGA_CYCLES_PER_BYTE = 9;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD_I,
    ST_KSA_WAIT_I,
    ST_KSA_RD_J,
    ST_KSA_WAIT_J,
    ST_KSA_WR_I,
    ST_KSA_WR_J,
    ST_PRGA_RD_I,
    ST_PRGA_WAIT_I,
    ST_PRGA_RD_J,
    ST_PRGA_WAIT_J,
    ST_PRGA_WR_I,
    ST_PRGA_WR_J,
    ST_PRGA_RD_F,
    ST_PRGA_WAIT_F,
    ST_PRGA_WR_D,
    ST_DONE
  } rc4_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plausibility check of one plaintext byte: lowercase letter or space.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_byte,
  output logic       char_ok
);

  assign char_ok = ((char_byte >= CHAR_LO) && (char_byte <= CHAR_HI)) ||
                   (char_byte == CHAR_SP);

endmodule

// File: rtl/rc4_engine.sv
// RC4 decryption engine: S init, KSA and PRGA/XOR driving external S, E and D RAMs.
// Optional build macro RC4_EARLY_ABORT_EN stops PRGA at the first implausible byte.
module rc4_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic                   key_valid,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [7:0]             e_addr,
  input  logic [7:0]             e_rdata,
  output logic [7:0]             d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren
);

  localparam int              KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(KEY_BYTES - 1);
  localparam logic [7:0]      LAST_K    = 8'(MSG_LEN - 1);

  rc4_state_t               state_reg, state_next;
  logic [8*KEY_BYTES-1:0]   key_reg, key_next;
  logic [7:0]               i_reg, i_next;
  logic [7:0]               j_reg, j_next;
  logic [7:0]               k_reg, k_next;
  logic [KIDX_W-1:0]        kidx_reg, kidx_next;
  logic [7:0]               si_reg, si_next;
  logic [7:0]               sj_reg, sj_next;
  logic [7:0]               f_reg, f_next;
  logic                     key_valid_reg, key_valid_next;

  logic [7:0] key_bytes [KEY_BYTES];
  logic [7:0] plain_byte;
  logic       char_ok;

  // Byte 0 of the key sits in the most significant byte lane.
  generate
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
      assign key_bytes[gi] = key_reg[8*(KEY_BYTES-1-gi) +: 8];
    end
  endgenerate

  assign plain_byte = f_reg ^ e_rdata;
  assign key_valid  = key_valid_reg;

  rc4_char_check u_char_check (
    .char_byte (plain_byte),
    .char_ok   (char_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      key_reg       <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      kidx_reg      <= '0;
      si_reg        <= '0;
      sj_reg        <= '0;
      f_reg         <= '0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      i_reg         <= i_next;
      j_reg         <= j_next;
      k_reg         <= k_next;
      kidx_reg      <= kidx_next;
      si_reg        <= si_next;
      sj_reg        <= sj_next;
      f_reg         <= f_next;
      key_valid_reg <= key_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    i_next         = i_reg;
    j_next         = j_reg;
    k_next         = k_reg;
    kidx_next      = kidx_reg;
    si_next        = si_reg;
    sj_next        = sj_reg;
    f_next         = f_reg;
    key_valid_next = key_valid_reg;
    busy           = 1'b1;
    done           = 1'b0;
    s_addr         = 8'h00;
    s_wdata        = 8'h00;
    s_wren         = 1'b0;
    e_addr         = 8'h00;
    d_addr         = 8'h00;
    d_wdata        = 8'h00;
    d_wren         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          key_next       = secret_key;
          i_next         = 8'h00;
          j_next         = 8'h00;
          k_next         = 8'h00;
          kidx_next      = '0;
          key_valid_next = 1'b1;
          state_next     = ST_INIT;
        end
      end
      ST_INIT: begin
        s_addr  = i_reg;
        s_wdata = i_reg;
        s_wren  = 1'b1;
        i_next  = i_reg + 8'd1;
        if (i_reg == 8'hFF) state_next = ST_KSA_RD_I;
      end
      ST_KSA_RD_I: begin
        s_addr = i_reg;
        if (i_reg == 8'h00) j_next = 8'h00;
        state_next = ST_KSA_WAIT_I;
      end
      ST_KSA_WAIT_I: begin
        si_next    = s_rdata;
        state_next = ST_KSA_RD_J;
      end
      ST_KSA_RD_J: begin
        j_next     = j_reg + si_reg + key_bytes[kidx_reg];
        s_addr     = j_next;
        state_next = ST_KSA_WAIT_J;
      end
      ST_KSA_WAIT_J: begin
        sj_next    = s_rdata;
        state_next = ST_KSA_WR_I;
      end
      ST_KSA_WR_I: begin
        s_addr     = i_reg;
        s_wdata    = sj_reg;
        s_wren     = 1'b1;
        state_next = ST_KSA_WR_J;
      end
      ST_KSA_WR_J: begin
        s_addr    = j_reg;
        s_wdata   = si_reg;
        s_wren    = 1'b1;
        i_next    = i_reg + 8'd1;
        kidx_next = (kidx_reg == LAST_KIDX) ? '0 : kidx_reg + 1'b1;
        if (i_reg == 8'hFF) begin
          // PRGA starts with i = k + 1 = 1 and a fresh j.
          i_next     = 8'd1;
          j_next     = 8'h00;
          k_next     = 8'h00;
          state_next = ST_PRGA_RD_I;
        end else begin
          state_next = ST_KSA_RD_I;
        end
      end
      ST_PRGA_RD_I: begin
        s_addr     = i_reg;
        state_next = ST_PRGA_WAIT_I;
      end
      ST_PRGA_WAIT_I: begin
        si_next    = s_rdata;
        state_next = ST_PRGA_RD_J;
      end
      ST_PRGA_RD_J: begin
        j_next     = j_reg + si_reg;
        s_addr     = j_next;
        state_next = ST_PRGA_WAIT_J;
      end
      ST_PRGA_WAIT_J: begin
        sj_next    = s_rdata;
        state_next = ST_PRGA_WR_I;
      end
      ST_PRGA_WR_I: begin
        s_addr     = i_reg;
        s_wdata    = sj_reg;
        s_wren     = 1'b1;
        state_next = ST_PRGA_WR_J;
      end
      ST_PRGA_WR_J: begin
        s_addr     = j_reg;
        s_wdata    = si_reg;
        s_wren     = 1'b1;
        state_next = ST_PRGA_RD_F;
      end
      ST_PRGA_RD_F: begin
        // After the swap S[i]+S[j] is the same sum as before it.
        s_addr     = si_reg + sj_reg;
        state_next = ST_PRGA_WAIT_F;
      end
      ST_PRGA_WAIT_F: begin
        f_next     = s_rdata;
        state_next = ST_PRGA_WR_D;
      end
      ST_PRGA_WR_D: begin
        d_addr  = k_reg;
        d_wdata = plain_byte;
        d_wren  = 1'b1;
        i_next  = i_reg + 8'd1;
        k_next  = k_reg + 8'd1;
        if (!char_ok) key_valid_next = 1'b0;
        if (k_reg == LAST_K) begin
          state_next = ST_DONE;
`ifdef RC4_EARLY_ABORT_EN
        end else if (!char_ok) begin
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_PRGA_RD_I;
        end
      end
      ST_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    if (state_reg inside {ST_PRGA_RD_I, ST_PRGA_WAIT_I, ST_PRGA_RD_J, ST_PRGA_WAIT_J,
                          ST_PRGA_WR_I, ST_PRGA_WR_J, ST_PRGA_RD_F, ST_PRGA_WAIT_F,
                          ST_PRGA_WR_D})
      e_addr = k_reg;
  end

endmodule
